instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 38 +++
 rtl/instr_fetch.sv | 73 +++++++
 tb/tb_instr_fetch.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;
  typedef logic [19:0] addr_t;
  typedef logic [31:0] instr_t;
  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } entry_t;
  localparam addr_t PC_INC = 20'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two FIFO of fetched {pc, instr} entries with flush and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output entry_t                   dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: prefetching instruction fetch unit with redirect and head-of-buffer handshake.
// Define INSTR_FETCH_MISALIGN_CHECK_EN to add misalign_o, flagging redirects to non-word-aligned targets.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC   = 20'h00000,
  parameter int    FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [19:0] mem_addr,
  output logic [31:0] mem_data_i,
  input  logic [31:0] mem_data_o,
  input  logic        redirect_i,
  input  logic [19:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [19:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  addr_t pc, inflight_pc;
  logic inflight, issue, push, pop;
  logic [CW-1:0] count;
  logic [CW:0] load;
  entry_t head, wr_entry;
  // an entry popped this cycle already counts as free space for a new read
  assign pop      = valid_o && ready_i && !redirect_i;
  assign push     = inflight && !redirect_i;
  assign load     = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight);
  assign issue    = rst_n && !redirect_i && (load < (CW+1)'(FIFO_DEPTH));
  assign wr_entry = '{pc: inflight_pc, instr: mem_data_o};
  assign mem_ren    = issue;
  assign mem_wen    = 1'b0;
  assign mem_addr   = pc;
  assign mem_data_i = '0;
  assign valid_o    = count != '0;
  assign instr_o    = valid_o ? head.instr : '0;
  assign pc_o       = valid_o ? head.pc : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC & ~20'd3;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      pc <= redirect_i ? (redirect_pc_i & ~20'd3) : issue ? pc + PC_INC : pc;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_i),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .count (count)
  );
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_o <= 1'b0;
    else misalign_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed bench comparing the fetch unit against an expected-PC-stream model.
module tb_instr_fetch;
  localparam int DEPTH = 2;
  localparam logic [19:0] RESET_PC = 20'h00000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_ren, mem_wen, valid_o, ready_i, redirect_i;
  logic [19:0] mem_addr, redirect_pc_i, pc_o;
  logic [31:0] mem_data_i, mem_data_o, instr_o;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  logic misalign_o;
`endif
  int vectors = 0, errors = 0;
  int issued, accepted, starve;
  logic [19:0] exp_pc, held_pc;
  logic [31:0] held_instr;
  logic held, post_redir, exp_mis;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o),
    .ready_i(ready_i)
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    , .misalign_o(misalign_o)
`endif
  );

  function automatic logic [31:0] word_at(input logic [19:0] a);
    return a == 20'h0 ? 32'h13 : a == 20'h4 ? 32'h93 : a == 20'h8 ? 32'h113 : {12'hC0D, a};
  endfunction

  // memory answers one cycle after a read; idle cycles return noise
  always @(posedge clk) mem_data_o <= mem_ren ? word_at(mem_addr) : $urandom();

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rdy, input logic redir, input logic [19:0] rpc);
    @(negedge clk);
    ready_i = rdy;
    redirect_i = redir;
    redirect_pc_i = rpc;
    #1;
    if (redir) check("ren_on_redirect", mem_ren, 0);
    if (post_redir) check("valid_after_redirect", valid_o, 0);
    if (mem_ren) check("addr_align", mem_addr[1:0], 0);
    check("wen", mem_wen, 0);
    check("wdata", mem_data_i, 0);
    if (held && valid_o) begin
      check("hold_pc", pc_o, held_pc);
      check("hold_instr", instr_o, held_instr);
    end
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    check("misalign", misalign_o, exp_mis);
`endif
    if (mem_ren) issued++;
    if (valid_o && rdy && !redir) begin
      check("pc", pc_o, exp_pc);
      check("instr", instr_o, word_at(exp_pc));
      exp_pc += 20'd4;
      accepted++;
    end
    check("occupancy_bound", (issued - accepted) <= DEPTH, 1);
    starve = (valid_o || redir) ? 0 : starve + 1;
    check("starve_bound", starve <= 2, 1);
    held = valid_o && !rdy && !redir;
    held_pc = pc_o;
    held_instr = instr_o;
    post_redir = redir;
    exp_mis = redir && (rpc[1:0] != 2'b00);
    if (redir) begin
      exp_pc = rpc & ~20'd3;
      issued = 0;
      accepted = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_i = 1'b0;
    ready_i = 1'b0;
    redirect_pc_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_ren", mem_ren, 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", pc_o, 0);
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    check("rst_misalign", misalign_o, 0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    exp_pc = RESET_PC;
    issued = 0;
    accepted = 0;
    starve = 0;
    held = 0;
    post_redir = 0;
    exp_mis = 0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_ren", mem_ren, 0);
    do_reset();
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      if (i == 0) begin
        check("first_ren", mem_ren, 1);
        check("first_addr", mem_addr, RESET_PC);
      end
      check("startup_valid", valid_o, i >= 2);
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      if (i >= 2) check("stall_ren", mem_ren, 0);
      check("stall_head", pc_o, 0);
    end
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    check("drain_count", accepted, 8);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("inflight_addr", mem_addr, 20'h8);
    step(1, 1, 20'h100);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    step(1, 1, 20'hFFFF8);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    check("wrap_count", accepted, 4);
    step(1, 1, 20'h102);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    mid_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    for (int i = 0; i < 500; i++) begin
      if (i == 250) mid_reset();
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 6, 20'($urandom()));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
